// File: rtl/hwpe_stream_realign_sequencer_if.sv
// Load-request channel of the realign sequencer: word request plus the
// per-word realigner controls that travel with it.
interface hwpe_stream_realign_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  localparam int unsigned B = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr;
  logic                  valid;
  logic                  ready;
  logic                  first;
  logic                  last;
  logic                  last_packet;
  logic                  strb_valid;
  logic [B-1:0]          strb;
  logic                  realign;
  logic [CNT_WIDTH-1:0]  line_length;

  modport master (
    output addr, valid, first, last, last_packet, strb_valid, strb, realign, line_length,
    input  ready
  );

  modport slave (
    input  addr, valid, first, last, last_packet, strb_valid, strb, realign, line_length,
    output ready
  );
endinterface

// File: rtl/hwpe_stream_realign_sequencer.sv
// Issues word-aligned loads for a strided 2D transfer with a possibly misaligned
// base, tagging each word with first/last/strobe controls; zero latency, holds on !ready.
module hwpe_stream_realign_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  line_words_i,
  input  logic [CNT_WIDTH-1:0]  n_lines_i,
  input  logic [ADDR_WIDTH-1:0] line_stride_i,
  hwpe_stream_realign_sequencer_if.master req,
  output logic                  enable_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned B = DATA_WIDTH / 8;
  localparam int unsigned O = $clog2(B);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;
  logic [CNT_WIDTH-1:0]  line_len_q, line_len_d;
  logic [CNT_WIDTH-1:0]  n_lines_q, n_lines_d;
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [O-1:0]          off_q, off_d;
  logic                  realign_q, realign_d;

  logic         issue, is_first, is_last, is_last_line;
  logic [B-1:0] head_strb;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      line_len_q  <= '0;
      n_lines_q   <= '0;
      line_base_q <= '0;
      stride_q    <= '0;
      off_q       <= '0;
      realign_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      line_cnt_q  <= line_cnt_d;
      line_len_q  <= line_len_d;
      n_lines_q   <= n_lines_d;
      line_base_q <= line_base_d;
      stride_q    <= stride_d;
      off_q       <= off_d;
      realign_q   <= realign_d;
    end
  end

  assign issue        = (state_q == ISSUE);
  assign is_first     = (word_cnt_q == '0);
  assign is_last      = (word_cnt_q == line_len_q - CNT_WIDTH'(1));
  assign is_last_line = (line_cnt_q == n_lines_q - CNT_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    line_cnt_d  = line_cnt_q;
    line_len_d  = line_len_q;
    n_lines_d   = n_lines_q;
    line_base_d = line_base_q;
    stride_d    = stride_q;
    off_d       = off_q;
    realign_d   = realign_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          off_d       = base_addr_i[O-1:0];
          realign_d   = (base_addr_i[O-1:0] != '0);
          line_len_d  = line_words_i + CNT_WIDTH'(base_addr_i[O-1:0] != '0);
          line_base_d = {base_addr_i[ADDR_WIDTH-1:O], {O{1'b0}}};
          n_lines_d   = n_lines_i;
          stride_d    = line_stride_i;
          word_cnt_d  = '0;
          line_cnt_d  = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (req.ready) begin
          if (is_last && is_last_line) begin
            state_d = DONE;
          end else if (is_last) begin
            word_cnt_d  = '0;
            line_cnt_d  = line_cnt_q + CNT_WIDTH'(1);
            line_base_d = line_base_q + stride_q;
          end else begin
            word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Clear wins over everything, including a start in the same cycle.
    if (clear_i) begin
      state_d     = IDLE;
      word_cnt_d  = '0;
      line_cnt_d  = '0;
      line_len_d  = '0;
      n_lines_d   = '0;
      line_base_d = '0;
      stride_d    = '0;
      off_d       = '0;
      realign_d   = 1'b0;
    end
  end

  // Leading word keeps the bytes at and above the offset, trailing word the rest.
  assign head_strb = {B{1'b1}} << off_q;

  always_comb begin
    req.valid       = issue;
    req.addr        = issue ? line_base_q + (ADDR_WIDTH'(word_cnt_q) << O) : '0;
    req.first       = issue & is_first;
    req.last        = issue & is_last;
    req.last_packet = issue & is_last & is_last_line;
    req.strb_valid  = issue & (is_first | is_last);
    req.strb        = '0;
    if (issue) begin
      if (!realign_q)    req.strb = '1;
      else if (is_first) req.strb = head_strb;
      else if (is_last)  req.strb = ~head_strb;
      else               req.strb = '1;
    end
    req.realign     = realign_q;
    req.line_length = line_len_q;
  end

  assign enable_o = enable_i;
  assign busy_o   = issue;
  assign done_o   = (state_q == DONE);

endmodule

// File: tb/tb_hwpe_stream_realign_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed request words, a negedge
// monitor pops them on each handshake and checks stability while stalled.
module tb_hwpe_stream_realign_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        enable_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [15:0] line_words_i = '0;
  logic [15:0] n_lines_i = '0;
  logic [31:0] line_stride_i = '0;
  logic        enable_o, busy_o, done_o;

  hwpe_stream_realign_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) req_if ();

  hwpe_stream_realign_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
    .start_i(start_i), .base_addr_i(base_addr_i), .line_words_i(line_words_i),
    .n_lines_i(n_lines_i), .line_stride_i(line_stride_i), .req(req_if.master),
    .enable_o(enable_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        f, l, lp, sv;
    logic [3:0]  strb;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        exp_realign = 1'b0;
  logic [15:0] exp_len = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic f, input logic l, input logic lp,
                      input logic [3:0] s);
    exp_t e;
    e.addr = a; e.f = f; e.l = l; e.lp = lp; e.sv = f | l; e.strb = s;
    q.push_back(e);
  endtask

  task automatic launch(input logic [31:0] base, input logic [15:0] words,
                        input logic [15:0] lines, input logic [31:0] stride,
                        input logic realign, input logic [15:0] len);
    base_addr_i = base; line_words_i = words; n_lines_i = lines; line_stride_i = stride;
    exp_realign = realign; exp_len = len;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_q(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #2;
      if (q.size() <= target) return;
    end
    checks++; errors++;
    $display("FAIL timeout: queue size %0d expected %0d", q.size(), target);
  endtask

  task automatic check_done();
    chk("done_pulse", done_o, 1);
    chk("valid_in_done", req_if.valid, 0);
    @(posedge clk_i); #2;
    chk("done_one_cycle", done_o, 0);
    chk("busy_after_done", busy_o, 0);
  endtask

  // Monitor: compare each accepted word; while stalled the word must not move.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && req_if.valid) begin
        if (req_if.ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got addr %0h expected no request", req_if.addr);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("addr", req_if.addr, e.addr);
            chk("first", req_if.first, e.f);
            chk("last", req_if.last, e.l);
            chk("last_packet", req_if.last_packet, e.lp);
            chk("strb_valid", req_if.strb_valid, e.sv);
            chk("strb", req_if.strb, e.strb);
            chk("realign", req_if.realign, exp_realign);
            chk("line_length", req_if.line_length, exp_len);
          end
        end else if (q.size() > 0) begin
          chk("stall_addr", req_if.addr, q[0].addr);
          chk("stall_first", req_if.first, q[0].f);
          chk("stall_last", req_if.last, q[0].l);
          chk("stall_strb", req_if.strb, q[0].strb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_if.ready = 1'b1;
    #12;
    chk("rst_valid", req_if.valid, 0);
    chk("rst_realign", req_if.realign, 0);
    chk("rst_line_length", req_if.line_length, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("enable_hi", enable_o, 1);
    enable_i = 1'b0; #1;
    chk("enable_lo", enable_o, 0);
    enable_i = 1'b1;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Aligned, two lines, always ready.
    push(32'h100, 1, 0, 0, 4'hF); push(32'h104, 0, 0, 0, 4'hF);
    push(32'h108, 0, 0, 0, 4'hF); push(32'h10C, 0, 1, 0, 4'hF);
    push(32'h140, 1, 0, 0, 4'hF); push(32'h144, 0, 0, 0, 4'hF);
    push(32'h148, 0, 0, 0, 4'hF); push(32'h14C, 0, 1, 1, 4'hF);
    launch(32'h100, 16'd4, 16'd2, 32'h40, 1'b0, 16'd4);
    wait_q(0, 40);
    check_done();

    // Misaligned single line: offset 2 -> head 0xC, tail 0x3.
    push(32'h100, 1, 0, 0, 4'hC); push(32'h104, 0, 0, 0, 4'hF);
    push(32'h108, 0, 1, 1, 4'h3);
    launch(32'h102, 16'd2, 16'd1, 32'h40, 1'b1, 16'd3);
    wait_q(0, 40);
    check_done();
    chk("realign_held", req_if.realign, 1);
    chk("line_length_held", req_if.line_length, 3);

    // Backpressure: stall three cycles on the second word of line two.
    push(32'h100, 1, 0, 0, 4'hF); push(32'h104, 0, 0, 0, 4'hF);
    push(32'h108, 0, 0, 0, 4'hF); push(32'h10C, 0, 1, 0, 4'hF);
    push(32'h140, 1, 0, 0, 4'hF); push(32'h144, 0, 0, 0, 4'hF);
    push(32'h148, 0, 0, 0, 4'hF); push(32'h14C, 0, 1, 1, 4'hF);
    launch(32'h100, 16'd4, 16'd2, 32'h40, 1'b0, 16'd4);
    wait_q(3, 40);
    req_if.ready = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    chk("stall_busy", busy_o, 1);
    req_if.ready = 1'b1;
    wait_q(0, 40);
    check_done();

    // Single-word lines; a start pulse mid-transfer must be ignored.
    push(32'h200, 1, 1, 0, 4'hF); push(32'h220, 1, 1, 0, 4'hF);
    push(32'h240, 1, 1, 1, 4'hF);
    launch(32'h200, 16'd1, 16'd3, 32'h20, 1'b0, 16'd1);
    wait_q(2, 40);
    base_addr_i = 32'h999; line_words_i = 16'd7; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    wait_q(0, 40);
    check_done();

    // Clear after two handshakes: idle next cycle, no done.
    push(32'h100, 1, 0, 0, 4'hF); push(32'h104, 0, 0, 0, 4'hF);
    push(32'h108, 0, 0, 0, 4'hF); push(32'h10C, 0, 1, 0, 4'hF);
    push(32'h140, 1, 0, 0, 4'hF); push(32'h144, 0, 0, 0, 4'hF);
    push(32'h148, 0, 0, 0, 4'hF); push(32'h14C, 0, 1, 1, 4'hF);
    launch(32'h100, 16'd4, 16'd2, 32'h40, 1'b0, 16'd4);
    wait_q(6, 40);
    req_if.ready = 1'b0; clear_i = 1'b1;
    @(posedge clk_i); #2;
    clear_i = 1'b0;
    chk("clear_valid", req_if.valid, 0);
    chk("clear_busy", busy_o, 0);
    chk("clear_done", done_o, 0);
    chk("clear_line_length", req_if.line_length, 0);
    @(posedge clk_i); #2;
    chk("clear_no_done", done_o, 0);
    q.delete();
    req_if.ready = 1'b1;
    push(32'h100, 1, 0, 0, 4'hC); push(32'h104, 0, 0, 0, 4'hF);
    push(32'h108, 0, 1, 1, 4'h3);
    launch(32'h102, 16'd2, 16'd1, 32'h40, 1'b1, 16'd3);
    wait_q(0, 40);
    check_done();

    // Asynchronous reset mid-transfer.
    push(32'h304, 1, 0, 0, 4'hC); push(32'h308, 0, 0, 0, 4'hF);
    push(32'h30C, 0, 0, 0, 4'hF); push(32'h310, 0, 1, 1, 4'h3);
    launch(32'h306, 16'd3, 16'd1, 32'h40, 1'b1, 16'd4);
    wait_q(2, 40);
    req_if.ready = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_valid", req_if.valid, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_realign", req_if.realign, 0);
    chk("arst_line_length", req_if.line_length, 0);
    q.delete();
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(posedge clk_i); #2;
    chk("post_rst_idle", req_if.valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
